// File: rtl/pe_pkg.sv
// Shared state encoding and sizing constants for the PE MAC step sequencer.
package pe_pkg;

  localparam int MAX_CH = 512;
  localparam int TAPS   = 3;
  localparam int PHASES = 4;
  localparam int CH_W   = 9;
  localparam int ADDR_W = 11;
  localparam int NCH_W  = CH_W + 1;
  localparam int PH_W   = 2;
  localparam int ROW_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } pe_state_e;

endpackage

// File: rtl/pe_step_counter.sv
// Nested phase -> tap row -> channel counter; clear wins over enable.
// Zero latency: wrap flags are decoded from the current count.
module pe_step_counter import pe_pkg::*; #(
  parameter int N_TAPS = TAPS
) (
  input  logic             clk,
  input  logic             mac_reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [NCH_W-1:0] num_ch_i,
  output logic [PH_W-1:0]  phase_o,
  output logic [ROW_W-1:0] row_o,
  output logic [CH_W-1:0]  ch_o,
  output logic             phase_wrap_o,
  output logic             last_o
);

  logic [PH_W-1:0]  phase_q, phase_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             row_wrap;

  assign phase_wrap_o = (phase_q == PH_W'(PHASES - 1));
  assign row_wrap     = phase_wrap_o && (row_q == ROW_W'(N_TAPS - 1));
  assign last_o       = row_wrap && ({1'b0, ch_q} == (num_ch_i - NCH_W'(1)));

  always_comb begin
    phase_d = phase_q;
    row_d   = row_q;
    ch_d    = ch_q;
    if (clr_i) begin
      phase_d = '0;
      row_d   = '0;
      ch_d    = '0;
    end else if (en_i) begin
      phase_d = phase_wrap_o ? '0 : phase_q + PH_W'(1);
      if (phase_wrap_o) begin
        row_d = row_wrap ? '0 : row_q + ROW_W'(1);
      end
      // Channel holds on the final step so ch_o never leaves 0..num_ch-1.
      if (row_wrap && !last_o) begin
        ch_d = ch_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge mac_reset) begin
    if (!mac_reset) begin
      phase_q <= '0;
      row_q   <= '0;
      ch_q    <= '0;
    end else begin
      phase_q <= phase_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
    end
  end

  assign phase_o = phase_q;
  assign row_o   = row_q;
  assign ch_o    = ch_q;

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequences MAC/accumulate steps over TAPS rows x num_ch channels per output window.
// Stall freezes stepping; the result is held in OUT until out_ready; abort cancels at once.
module pe_seq_ctrl import pe_pkg::*; #(
  parameter int MAX_CH = pe_pkg::MAX_CH,
  parameter int TAPS   = pe_pkg::TAPS
) (
  input  logic              clk,
  input  logic              mac_reset,
  input  logic              start,
  input  logic [NCH_W-1:0]  num_ch,
  input  logic              stall,
  input  logic              abort,
  input  logic              out_ready,
  output logic              busy,
  output logic [PH_W-1:0]   mac_phase,
  output logic              mac_en,
  output logic [ROW_W-1:0]  tap_row,
  output logic [CH_W-1:0]   ch_idx,
  output logic [ADDR_W-1:0] flt_addr,
  output logic              acc_en,
  output logic              acc_clr,
  output logic              out_valid,
  output logic              done,
  output logic              cfg_err
);

  pe_state_e        state_q, state_d;
  logic [NCH_W-1:0] num_ch_q, num_ch_d;
  logic             mac_en_q, mac_en_d;
  logic             acc_en_q, acc_en_d;
  logic             acc_clr_q, acc_clr_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_ok;
  logic             accept;
  logic             cnt_en;
  logic             cnt_clr;
  logic             phase_wrap;
  logic             last_step;
  logic [PH_W-1:0]  phase_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [CH_W-1:0]  ch_cnt;

  assign cfg_ok   = (num_ch != '0) && (int'(num_ch) <= MAX_CH);
  assign accept   = (state_q == IDLE) && start && cfg_ok;
  assign cnt_en   = (state_q == RUN) && !stall && !abort;
  // Counters sit at zero in IDLE and LOAD, so every window starts clean.
  assign cnt_clr  = (state_d == IDLE) || (state_d == LOAD);
  assign num_ch_d = accept ? num_ch : num_ch_q;

  pe_step_counter #(
    .N_TAPS (TAPS)
  ) u_step_counter (
    .clk          (clk),
    .mac_reset    (mac_reset),
    .clr_i        (cnt_clr),
    .en_i         (cnt_en),
    .num_ch_i     (num_ch_q),
    .phase_o      (phase_cnt),
    .row_o        (row_cnt),
    .ch_o         (ch_cnt),
    .phase_wrap_o (phase_wrap),
    .last_o       (last_step)
  );

  always_ff @(posedge clk or negedge mac_reset) begin
    if (!mac_reset) begin
      state_q     <= IDLE;
      num_ch_q    <= '0;
      mac_en_q    <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_ch_q    <= num_ch_d;
      mac_en_q    <= mac_en_d;
      acc_en_q    <= acc_en_d;
      acc_clr_q   <= acc_clr_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (cnt_en && last_step) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Step strobes are registered: each marks the step retired at the previous edge.
  always_comb begin
    acc_clr_d   = (state_d == LOAD);
    mac_en_d    = cnt_en && !phase_wrap;
    acc_en_d    = cnt_en && phase_wrap;
    out_valid_d = (state_d == OUT);
    done_d      = (state_q == OUT) && out_ready && !abort;
    cfg_err_d   = (state_q == IDLE) && start && !cfg_ok;
  end

  assign busy      = (state_q != IDLE);
  assign mac_phase = phase_cnt;
  assign tap_row   = row_cnt;
  assign ch_idx    = ch_cnt;
  assign flt_addr  = ADDR_W'(ch_cnt) * ADDR_W'(TAPS) + ADDR_W'(row_cnt);
  assign mac_en    = mac_en_q;
  assign acc_en    = acc_en_q;
  assign acc_clr   = acc_clr_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: cycle k is the interval after the k-th rising edge
// following the cycle in which start is driven (start cycle = 0).
module tb_pe_seq_ctrl;

  logic        clk = 1'b0;
  logic        mac_reset;
  logic        start;
  logic [9:0]  num_ch;
  logic        stall;
  logic        abort;
  logic        out_ready;
  logic        busy;
  logic [1:0]  mac_phase;
  logic        mac_en;
  logic [1:0]  tap_row;
  logic [8:0]  ch_idx;
  logic [10:0] flt_addr;
  logic        acc_en;
  logic        acc_clr;
  logic        out_valid;
  logic        done;
  logic        cfg_err;

  int n_chk  = 0;
  int n_pass = 0;

  pe_seq_ctrl #(
    .MAX_CH (512),
    .TAPS   (3)
  ) dut (
    .clk       (clk),
    .mac_reset (mac_reset),
    .start     (start),
    .num_ch    (num_ch),
    .stall     (stall),
    .abort     (abort),
    .out_ready (out_ready),
    .busy      (busy),
    .mac_phase (mac_phase),
    .mac_en    (mac_en),
    .tap_row   (tap_row),
    .ch_idx    (ch_idx),
    .flt_addr  (flt_addr),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  initial begin
    int cyc;
    int n_mac;
    int n_acc;
    int n_done;
    int n_busy;
    int n_ov;
    int last_addr;
    int bad_ch[3];

    bad_ch = '{0, 513, 1023};
    mac_reset = 1'b0;
    start = 1'b0;
    num_ch = '0;
    stall = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flt_addr", 32'(flt_addr), 0);
    chk("rst_strobes", 32'({mac_en, acc_en, acc_clr, out_valid, done, cfg_err}), 0);
    chk("rst_counters", 32'({mac_phase, tap_row, ch_idx}), 0);
    tick();
    mac_reset = 1'b1;
    tick();

    // Basic window, num_ch=1
    start = 1'b1;
    num_ch = 10'd1;
    tick();
    start = 1'b0;
    chk("basic_acc_clr_c1", 32'(acc_clr), 1);
    chk("basic_busy_c1", 32'(busy), 1);
    n_mac = 0;
    n_acc = 0;
    for (int c = 2; c <= 13; c++) begin
      tick();
      chk("basic_phase_row", 32'({mac_phase, tap_row}), ((c - 2) % 4) * 4 + (c - 2) / 4);
      if (mac_en) n_mac++;
      if (acc_en) n_acc++;
    end
    chk("basic_flt_addr_c13", 32'(flt_addr), 2);
    chk("basic_mac_en_count", n_mac, 9);
    chk("basic_acc_en_count", n_acc, 2);
    chk("basic_ovld_c13", 32'(out_valid), 0);
    tick();
    chk("basic_ovld_c14", 32'(out_valid), 1);
    chk("basic_acc_en_c14", 32'(acc_en), 1);
    chk("basic_done_c14", 32'(done), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic_done_c15", 32'(done), 1);
    chk("basic_busy_c15", 32'(busy), 0);
    chk("basic_ovld_c15", 32'(out_valid), 0);
    tick();
    chk("basic_done_c16", 32'(done), 0);

    // Configuration errors
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      num_ch = 10'(bad_ch[i]);
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", 32'(cfg_err), 1);
      chk("cfg_busy", 32'(busy), 0);
      tick();
      chk("cfg_err_clear", 32'(cfg_err), 0);
      chk("cfg_busy_after", 32'(busy), 0);
    end

    // Stall at phase 1, row 2, ch 0 for cycles 11..15
    start = 1'b1;
    num_ch = 10'd1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("stall_pos_c11", 32'({mac_phase, tap_row, ch_idx}), 32'({2'd1, 2'd2, 9'd0}));
    stall = 1'b1;
    for (int k = 12; k <= 16; k++) begin
      tick();
      if (k == 16) stall = 1'b0;
      chk("stall_frozen", 32'({mac_phase, tap_row, ch_idx}), 32'({2'd1, 2'd2, 9'd0}));
      chk("stall_mac_en", 32'({mac_en, acc_en}), 0);
    end
    cyc = 16;
    while (out_valid !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("stall_ovld_cycle", cyc, 19);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_done", 32'(done), 1);

    // Abort mid-RUN while stalled, num_ch=2
    start = 1'b1;
    num_ch = 10'd2;
    tick();
    start = 1'b0;
    repeat (6) tick();
    stall = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    stall = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_strobes", 32'({mac_en, acc_en, acc_clr, out_valid, done}), 0);
    chk("abort_counters", 32'({mac_phase, tap_row, ch_idx}), 0);
    n_done = 0;
    n_busy = 0;
    repeat (30) begin
      tick();
      if (done) n_done++;
      if (busy) n_busy++;
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_stays_idle", n_busy, 0);

    // Abort in OUT beats out_ready
    start = 1'b1;
    num_ch = 10'd1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("abort_out_reach", cyc, 14);
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_out_state", 32'({busy, out_valid, done}), 0);
    tick();
    chk("abort_out_no_done", 32'(done), 0);

    // Reset mid-RUN discards the window
    start = 1'b1;
    num_ch = 10'd1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    mac_reset = 1'b0;
    #1;
    chk("rrun_busy", 32'(busy), 0);
    chk("rrun_state", 32'({mac_phase, tap_row, ch_idx, flt_addr, mac_en, acc_en}), 0);
    tick();
    mac_reset = 1'b1;
    n_busy = 0;
    n_done = 0;
    repeat (20) begin
      tick();
      if (busy) n_busy++;
      if (done) n_done++;
    end
    chk("rrun_needs_start", n_busy, 0);
    chk("rrun_no_done", n_done, 0);

    // Maximum window, start while busy ignored, then output backpressure
    start = 1'b1;
    num_ch = 10'd512;
    tick();
    start = 1'b0;
    num_ch = 10'd3;
    cyc = 1;
    n_acc = 0;
    last_addr = -1;
    while (out_valid !== 1'b1 && cyc < 7000) begin
      start = (cyc == 100);
      last_addr = int'(flt_addr);
      if (acc_en) n_acc++;
      tick();
      cyc++;
    end
    start = 1'b0;
    if (acc_en) n_acc++;
    chk("max_ovld_cycle", cyc, 6146);
    chk("max_last_addr", last_addr, 1535);
    chk("max_acc_en_count", n_acc, 1536);
    n_ov = 0;
    n_done = 0;
    start = 1'b1;
    repeat (10) begin
      if (out_valid) n_ov++;
      if (done) n_done++;
      tick();
    end
    start = 1'b0;
    chk("bp_ovld_held", n_ov, 10);
    chk("bp_no_early_done", n_done, 0);
    chk("bp_ovld_still", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_done = 0;
    repeat (5) begin
      if (done) n_done++;
      tick();
    end
    chk("bp_single_done", n_done, 1);
    chk("bp_idle_after", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
